// File: rtl/rc4_stream_source_if.sv
// Host-load and core-stream signal bundle for rc4_stream_source.
// The master modport is the stream source itself; slave is the host/core side.
interface rc4_stream_source_if;
  logic       host_key_we;
  logic [7:0] host_key_data;
  logic       host_msg_we;
  logic [7:0] host_msg_data;
  logic       start;
  logic       busy;
  logic       load_err;
  logic       key_valid;
  logic [7:0] key_in;
  logic       plain_read;
  logic       plain_in_valid;
  logic [7:0] plain_in;
  logic       done;

  modport master (
    input  host_key_we, host_key_data, host_msg_we, host_msg_data, start, plain_read,
    output busy, load_err, key_valid, key_in, plain_in_valid, plain_in, done
  );

  modport slave (
    output host_key_we, host_key_data, host_msg_we, host_msg_data, start, plain_read,
    input  busy, load_err, key_valid, key_in, plain_in_valid, plain_in, done
  );
endinterface

// File: rtl/rc4_stream_source.sv
// Buffers a host-loaded key and plaintext, then bursts the key to the RC4 core and
// serves the core's plaintext read requests one byte per cycle.
module rc4_stream_source #(
  parameter int unsigned KEY_DEPTH = 32,
  parameter int unsigned MSG_DEPTH = 64,
  parameter int unsigned MAW       = 7
) (
  input logic                 clk,
  input logic                 rst,
  rc4_stream_source_if.master bus
);
  localparam int unsigned KAW = $clog2(KEY_DEPTH + 1);
  localparam int unsigned KIW = $clog2(KEY_DEPTH);
  localparam int unsigned MIW = $clog2(MSG_DEPTH);
  localparam logic [KAW-1:0] KeyFull = KAW'(KEY_DEPTH);
  localparam logic [MAW-1:0] MsgFull = MAW'(MSG_DEPTH);

  typedef enum logic [2:0] {StIdle, StKeyOut, StWaitRead, StStream, StFinish} state_e;

  state_e         state_q, state_d;
  logic [KAW-1:0] key_cnt_q, key_cnt_d, key_ptr_q, key_ptr_d;
  logic [MAW-1:0] msg_cnt_q, msg_cnt_d, msg_ptr_q, msg_ptr_d;
  logic           busy_q, busy_d, load_err_q, load_err_d, done_q, done_d;
  logic           key_valid_q, key_valid_d, plain_in_valid_q, plain_in_valid_d;
  logic [7:0]     key_in_q, key_in_d, plain_in_q, plain_in_d;
  logic           key_wr, msg_wr;

  logic [7:0] key_mem [KEY_DEPTH];
  logic [7:0] msg_mem [MSG_DEPTH];

  always_comb begin
    state_d          = state_q;
    key_cnt_d        = key_cnt_q;
    key_ptr_d        = key_ptr_q;
    msg_cnt_d        = msg_cnt_q;
    msg_ptr_d        = msg_ptr_q;
    busy_d           = busy_q;
    load_err_d       = load_err_q;
    done_d           = 1'b0;
    key_valid_d      = 1'b0;
    key_in_d         = 8'h00;
    plain_in_valid_d = 1'b0;
    plain_in_d       = 8'h00;
    key_wr           = 1'b0;
    msg_wr           = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.host_key_we) begin
          if (key_cnt_q < KeyFull) begin
            key_wr    = 1'b1;
            key_cnt_d = key_cnt_q + KAW'(1);
          end else begin
            load_err_d = 1'b1;
          end
        end
        if (bus.host_msg_we) begin
          if (msg_cnt_q < MsgFull) begin
            msg_wr    = 1'b1;
            msg_cnt_d = msg_cnt_q + MAW'(1);
          end else begin
            load_err_d = 1'b1;
          end
        end
        // A write in the start cycle counts, so judge emptiness on the updated count.
        if (bus.start) begin
          if (key_cnt_d == '0) begin
            load_err_d = 1'b1;
          end else begin
            state_d     = StKeyOut;
            busy_d      = 1'b1;
            key_valid_d = 1'b1;
            key_in_d    = (key_cnt_q == '0) ? bus.host_key_data : key_mem[0];
            key_ptr_d   = KAW'(1);
          end
        end
      end
      StKeyOut: begin
        if (key_ptr_q < key_cnt_q) begin
          key_valid_d = 1'b1;
          key_in_d    = key_mem[key_ptr_q[KIW-1:0]];
          key_ptr_d   = key_ptr_q + KAW'(1);
        end else begin
          state_d = StWaitRead;
        end
      end
      StWaitRead: begin
        if (bus.plain_read) begin
          if (msg_cnt_q == '0) begin
            state_d = StFinish;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d          = StStream;
            plain_in_valid_d = 1'b1;
            plain_in_d       = msg_mem[0];
            msg_ptr_d        = MAW'(1);
          end
        end
      end
      StStream: begin
        if (msg_ptr_q == msg_cnt_q) begin
          state_d = StFinish;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else if (bus.plain_read) begin
          plain_in_valid_d = 1'b1;
          plain_in_d       = msg_mem[msg_ptr_q[MIW-1:0]];
          msg_ptr_d        = msg_ptr_q + MAW'(1);
        end
      end
      StFinish: begin
        state_d   = StIdle;
        key_cnt_d = '0;
        key_ptr_d = '0;
        msg_cnt_d = '0;
        msg_ptr_d = '0;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q          <= StIdle;
      key_cnt_q        <= '0;
      key_ptr_q        <= '0;
      msg_cnt_q        <= '0;
      msg_ptr_q        <= '0;
      busy_q           <= 1'b0;
      load_err_q       <= 1'b0;
      done_q           <= 1'b0;
      key_valid_q      <= 1'b0;
      key_in_q         <= 8'h00;
      plain_in_valid_q <= 1'b0;
      plain_in_q       <= 8'h00;
    end else begin
      state_q          <= state_d;
      key_cnt_q        <= key_cnt_d;
      key_ptr_q        <= key_ptr_d;
      msg_cnt_q        <= msg_cnt_d;
      msg_ptr_q        <= msg_ptr_d;
      busy_q           <= busy_d;
      load_err_q       <= load_err_d;
      done_q           <= done_d;
      key_valid_q      <= key_valid_d;
      key_in_q         <= key_in_d;
      plain_in_valid_q <= plain_in_valid_d;
      plain_in_q       <= plain_in_d;
    end
  end

  // Buffer contents need no reset; the counts alone say what is valid.
  always_ff @(posedge clk) begin
    if (key_wr) key_mem[key_cnt_q[KIW-1:0]] <= bus.host_key_data;
    if (msg_wr) msg_mem[msg_cnt_q[MIW-1:0]] <= bus.host_msg_data;
  end

  assign bus.busy           = busy_q;
  assign bus.load_err       = load_err_q;
  assign bus.done           = done_q;
  assign bus.key_valid      = key_valid_q;
  assign bus.key_in         = key_in_q;
  assign bus.plain_in_valid = plain_in_valid_q;
  assign bus.plain_in       = plain_in_q;
endmodule

// File: doc/rc4_stream_source.md
Name: rc4_stream_source

Overview:
Upstream feeder for the RC4 cipher core. A host loads a key (1..KEY_DEPTH bytes) and a plaintext message (0..MSG_DEPTH bytes) into internal buffers, then pulses start. The block streams the key to the core as a contiguous key_valid burst, then serves the core's plain_read requests with one plaintext byte per cycle until the message is exhausted.

Parameters:
KEY_DEPTH, 32, key buffer depth in bytes; matches the core's key memory.
MSG_DEPTH, 64, message buffer depth in bytes.
MAW, 7, message pointer/count width; must satisfy 2**MAW > MSG_DEPTH.

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  asynchronous, active-low reset; rst=0 resets immediately, release is synchronous to clk
host_key_we  in  1  append host_key_data to the key buffer
host_key_data  in  8  key byte
host_msg_we  in  1  append host_msg_data to the message buffer
host_msg_data  in  8  plaintext byte
start  in  1  begin a transfer; sampled only in IDLE
busy  out  1  high from start acceptance until done
load_err  out  1  sticky error: buffer overflow, or start with an empty key
key_valid  out  1  key byte valid to the core
key_in  out  8  key byte to the core
plain_read  in  1  core is requesting plaintext
plain_in_valid  out  1  plaintext byte valid to the core
plain_in  out  8  plaintext byte to the core
done  out  1  one-cycle pulse at end of transfer

Behaviour:
- All outputs are registered. Reset values: busy=0, load_err=0, key_valid=0, key_in=0, plain_in_valid=0, plain_in=0, done=0. Key count, message count and pointers are cleared; buffer contents are undefined.
- States: IDLE, KEY_OUT, WAIT_READ, STREAM, FINISH.
- IDLE:
  - host_key_we writes key[key_cnt] and increments key_cnt when key_cnt<KEY_DEPTH. Otherwise the byte is dropped and load_err is set.
  - host_msg_we is handled the same way against MSG_DEPTH. Both writes may occur in the same cycle.
  - start with key_cnt==0 sets load_err and stays in IDLE.
  - start with key_cnt>=1 moves to KEY_OUT and sets busy. A start and a host write in the same cycle: the write lands first and is counted.
- Host writes and start received outside IDLE are ignored, with no error.
- KEY_OUT:
  - If start is accepted at edge N, key_valid=1 after edge N and key_in=key[0].
  - One byte is presented per cycle, in order, with no gaps. key_valid is high for exactly key_cnt cycles.
  - After the last byte, key_valid=0 and key_in returns to 0; the state moves to WAIT_READ.
- WAIT_READ:
  - Outputs hold low until plain_read is sampled 1.
  - If msg_cnt==0, go to FINISH and never assert plain_in_valid.
  - Otherwise go to STREAM and serve that same request cycle: plain_in_valid=1 and plain_in=msg[0] after that edge.
- STREAM, on each edge:
  - If plain_read=1 and msg_ptr<msg_cnt: plain_in_valid=1, plain_in=msg[msg_ptr], msg_ptr++.
  - If plain_read=0: plain_in_valid=0, msg_ptr holds, and the stream resumes on the next plain_read=1 without skipping or repeating a byte.
  - If msg_ptr==msg_cnt: plain_in_valid=0 and the state moves to FINISH.
- FINISH:
  - done=1 for one cycle, busy=0.
  - key_cnt, msg_cnt and pointers clear; load_err keeps its value.
  - Return to IDLE.
- load_err clears only on reset.
- rst asserted mid-transfer: all outputs drop to reset values immediately and counts clear. A partially streamed message is abandoned.
- The pointer compare uses the full MAW width, so msg_cnt==MSG_DEPTH streams all bytes without wrapping.

Test Plan:
- Load key {01,02,03}, message {AA,BB,CC}, start; hold plain_read=1 from 2 cycles after key end -> key_valid high exactly 3 cycles with key_in 01,02,03; plain_in_valid high 3 consecutive cycles carrying AA,BB,CC, then low; done pulses once; busy falls with done.
- Same load; drop plain_read for 2 cycles after the first byte -> plain_in sequence is AA (gap 2 cycles) BB,CC; no byte repeated or lost.
- Write 33 key bytes 00..20 -> load_err=1 after the 33rd write; a following start streams exactly 32 key bytes 00..1F.
- start with no key loaded -> load_err=1, busy stays 0, key_valid never asserts.
- Key {5A}, empty message, start; plain_read=1 -> key_valid 1 cycle; plain_in_valid never asserts; done pulses the cycle after plain_read is sampled.
- Load 64 message bytes 00..3F, start, assert rst=0 after 10 bytes have been served -> all outputs 0 immediately; after release, busy=0, load_err=0, and a fresh load/start streams correctly from byte 0.
